// File: rtl/tlul_rsp_intg_err_ctrl_if.sv
// Report-channel bundle between the integrity error controller and its environment.
// Optional ovf_o exists only when TLUL_RSP_INTG_ERR_OVF_EN is defined.
`timescale 1ns/1ps
interface tlul_rsp_intg_err_ctrl_if #(
    parameter int NumHosts = 4,
    parameter int CntW     = 8
);
    localparam int IdxW = $clog2(NumHosts);

    logic [NumHosts-1:0]      err_i;
    logic [CntW-1:0]          thresh_i;
    logic                     clr_i;
    logic                     rpt_valid_o;
    logic                     rpt_ready_i;
    logic [IdxW-1:0]          rpt_idx_o;
    logic [NumHosts*CntW-1:0] cnt_o;
    logic [NumHosts-1:0]      pending_o;
    logic                     fatal_o;
`ifdef TLUL_RSP_INTG_ERR_OVF_EN
    logic [NumHosts-1:0]      ovf_o;
`endif

    modport master (
        output err_i, thresh_i, clr_i, rpt_ready_i,
        input  rpt_valid_o, rpt_idx_o, cnt_o, pending_o, fatal_o
`ifdef TLUL_RSP_INTG_ERR_OVF_EN
        , input ovf_o
`endif
    );

    modport slave (
        input  err_i, thresh_i, clr_i, rpt_ready_i,
        output rpt_valid_o, rpt_idx_o, cnt_o, pending_o, fatal_o
`ifdef TLUL_RSP_INTG_ERR_OVF_EN
        , output ovf_o
`endif
    );
endinterface

// File: rtl/tlul_rsp_intg_err_ctrl.sv
// Per-host response-integrity error collector: pending reports, round-robin report channel,
// saturating counters and sticky fatal flag. Optional lost-report flags: TLUL_RSP_INTG_ERR_OVF_EN.
`timescale 1ns/1ps
module tlul_rsp_intg_err_ctrl #(
    parameter int NumHosts = 4,
    parameter int CntW     = 8
) (
    input logic                     clk_i,
    input logic                     rst_i,
    tlul_rsp_intg_err_ctrl_if.slave bus
);
    localparam int IdxW = $clog2(NumHosts);
    localparam logic [CntW-1:0] CntMax = '1;

    if (NumHosts < 2 || NumHosts > 16) begin : g_param_err
        $error("tlul_rsp_intg_err_ctrl: NumHosts must be within 2..16");
    end

    logic [NumHosts-1:0] r_pending;
    logic [IdxW-1:0]     r_ptr;
    logic                r_hold;
    logic [IdxW-1:0]     r_hold_idx;
    logic                r_fatal;

    logic [IdxW-1:0]     w_scan [NumHosts];
    logic [IdxW-1:0]     w_rr_idx;
    logic                w_rr_found;
    logic [IdxW-1:0]     w_grant_idx;
    logic                w_valid;
    logic                w_accept;
    logic [NumHosts-1:0] w_accept_mask;
    logic [NumHosts-1:0] w_pending_next;
    logic [NumHosts-1:0] w_hit;

    genvar gi;

    // Candidate order for the round-robin search, starting at the pointer and wrapping.
    for (gi = 0; gi < NumHosts; gi++) begin : g_scan
        assign w_scan[gi] = IdxW'((int'(r_ptr) + gi) % NumHosts);
    end

    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int k = 0; k < NumHosts; k++) begin
            if (!w_rr_found && r_pending[w_scan[k]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_scan[k];
            end
        end
    end

    // A stalled grant is latched so a newly pending host cannot steal the channel mid-handshake.
    assign w_valid     = |r_pending;
    assign w_grant_idx = r_hold ? r_hold_idx : w_rr_idx;
    assign w_accept    = w_valid & bus.rpt_ready_i;

    for (gi = 0; gi < NumHosts; gi++) begin : g_accept
        assign w_accept_mask[gi] = w_accept && (w_grant_idx == IdxW'(gi));
    end

    // A fresh error on the host being accepted re-arms its report.
    assign w_pending_next = (r_pending & ~w_accept_mask) | bus.err_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pending  <= '0;
            r_ptr      <= '0;
            r_hold     <= 1'b0;
            r_hold_idx <= '0;
            r_fatal    <= 1'b0;
        end else if (bus.clr_i) begin
            r_pending  <= '0;
            r_ptr      <= '0;
            r_hold     <= 1'b0;
            r_hold_idx <= '0;
            r_fatal    <= 1'b0;
        end else begin
            r_pending  <= w_pending_next;
            r_hold     <= w_valid & ~bus.rpt_ready_i;
            r_hold_idx <= w_grant_idx;
            r_fatal    <= r_fatal | (|w_hit);
            if (w_accept) begin
                r_ptr <= (w_grant_idx == IdxW'(NumHosts - 1)) ? '0 : w_grant_idx + IdxW'(1);
            end
        end
    end

    for (gi = 0; gi < NumHosts; gi++) begin : g_cnt
        logic [CntW-1:0] r_cnt;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_cnt <= '0;
            end else if (bus.clr_i) begin
                r_cnt <= '0;
            end else if (bus.err_i[gi] && (r_cnt != CntMax)) begin
                r_cnt <= r_cnt + CntW'(1);
            end
        end

        // Threshold of zero means fatal reporting is disabled.
        assign w_hit[gi] = (bus.thresh_i != '0) && (r_cnt == bus.thresh_i);
        assign bus.cnt_o[gi*CntW +: CntW] = r_cnt;
    end

`ifdef TLUL_RSP_INTG_ERR_OVF_EN
    logic [NumHosts-1:0] r_ovf;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ovf <= '0;
        end else if (bus.clr_i) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= r_ovf | (bus.err_i & r_pending & ~w_accept_mask);
        end
    end

    assign bus.ovf_o = r_ovf;
`endif

    assign bus.rpt_valid_o = w_valid;
    assign bus.rpt_idx_o   = w_valid ? w_grant_idx : '0;
    assign bus.pending_o   = r_pending;
    assign bus.fatal_o     = r_fatal;

`ifndef SYNTHESIS
    a_idx_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.rpt_valid_o && !bus.rpt_ready_i && !bus.clr_i) |=> $stable(bus.rpt_idx_o));

    a_valid_known: assert property (@(posedge clk_i) disable iff (rst_i)
        !$isunknown(bus.rpt_valid_o));
`endif

endmodule

// File: doc/tlul_rsp_intg_err_ctrl.md
Name: tlul_rsp_intg_err_ctrl

Overview:
- Collects the per-host response-integrity error pulses from NumHosts response checkers. Each pulse is already qualified by d_valid.
- Queues one pending report per host and round-robin arbitrates the reports onto a single valid/ready report channel toward the alert/status logic.
- Keeps a saturating per-host error count and raises a sticky fatal flag when any count reaches a programmed threshold.
- Sits next to the host-side response checkers in the TL-UL crossbar/host wrappers.

Parameters:
- NumHosts, 4, number of monitored host ports (2..16).
- CntW, 8, width of each per-host error counter.
- IdxW, $clog2(NumHosts), width of the reported host index (derived, not overridable).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- err_i  input  NumHosts  per-host integrity error pulse, one bit per checker.
- thresh_i  input  CntW  fatal threshold; 0 disables fatal.
- clr_i  input  1  synchronous clear of counters, pending bits and fatal.
- rpt_valid_o  output  1  report available.
- rpt_ready_i  input  1  report consumer ready.
- rpt_idx_o  output  IdxW  host index of the current report.
- cnt_o  output  NumHosts*CntW  per-host error counts, packed with host 0 in the LSBs.
- pending_o  output  NumHosts  per-host pending report bits.
- fatal_o  output  1  sticky threshold-reached flag.

Behaviour:
- Reset: all counters 0, pending 0, fatal_o 0, rpt_valid_o 0, rpt_idx_o 0, round-robin pointer 0.
- Clock and reset: single clock domain; all state asynchronously reset by rst_i.
- Pending bits:
  - err_i[h]=1 sets pending[h] at the next edge.
  - An accepted handshake (rpt_valid_o & rpt_ready_i) on host h clears pending[h].
  - If err_i[h] and an accept of h occur in the same cycle, pending[h] stays 1: the new error wins.
- Arbiter:
  - Combinational round-robin over pending, searching upward from ptr and wrapping at NumHosts-1 to 0.
  - rpt_valid_o = |pending. rpt_idx_o = winning index, or 0 when nothing is pending.
  - Latency: err_i to rpt_valid_o is 1 cycle.
  - The grant is held stable while rpt_valid_o=1 and rpt_ready_i=0 (AXI-style hold).
  - The pointer only advances on accept, to (granted idx + 1) mod NumHosts.
- Counters:
  - cnt[h] increments by 1 on err_i[h].
  - Saturates at 2^CntW-1 and never wraps.
- Fatal:
  - fatal_o is set the cycle after any cnt[h] equals a nonzero thresh_i, compared on registered counts.
  - Once set, fatal_o stays 1 until clr_i or reset.
  - A thresh_i change never clears fatal_o.
- clr_i:
  - Zeroes counters, pending, fatal and ptr at the next edge.
  - It has priority over a simultaneous err_i, so errors in the clr cycle are dropped.
  - An accept in the same cycle is consumed with no effect.
- Simultaneous errors on several hosts: all pending bits are set; reports are drained one per accepted cycle in round-robin order.
- Reset mid-handshake: all state is dropped immediately; no report is replayed.
- Assertions:
  - rpt_idx_o stable while valid and not ready.
  - rpt_valid_o known after reset.
  - NumHosts >= 2.

Optional Feature:
- Macro: TLUL_RSP_INTG_ERR_OVF_EN.
- When defined:
  - Adds output ovf_o (NumHosts bits).
  - ovf_o[h] sets when err_i[h] arrives while pending[h] is already 1 and is not being accepted that cycle, i.e. a report was lost.
  - ovf_o is sticky until clr_i or reset, and resets to 0.
- When undefined: the port and logic are absent; lost reports are silently merged.

Test Plan:
- Reset then idle, NumHosts=4: rpt_valid_o=0, cnt_o=0, fatal_o=0 for 10 cycles.
- Single pulse err_i=4'b0100, rpt_ready_i=1:
  - Next cycle rpt_valid_o=1 and rpt_idx_o=2.
  - The cycle after, pending=0 and cnt[2]=1.
- err_i=4'b1011 in one cycle, rpt_ready_i held 0 for 3 cycles then 1:
  - rpt_idx_o stays 0 while stalled.
  - Accept order is 0, 1, 3; then rpt_valid_o=0.
- thresh_i=3, three pulses on host 1:
  - cnt[1]=3 and fatal_o=1 one cycle later.
  - A fourth pulse gives cnt[1]=4 and fatal_o stays 1.
  - clr_i=1 then gives cnt=0 and fatal_o=0.
- CntW=8, 300 pulses on host 0: cnt[0]=255, no wrap.
- err_i[3] coincident with an accept of host 3: pending[3] stays 1 and a second report for host 3 follows. With TLUL_RSP_INTG_ERR_OVF_EN, ovf_o stays 0 in this case; a pulse while stalled sets ovf_o[3]=1.
